// File: rtl/cube.sv
// cube: sequential unsigned 8-bit cube (24-bit exact) using one shift-add multiplier run twice.
module cube (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  x_bi,
    output logic        busy_o,
    output logic [23:0] y_bo
);
    typedef enum logic [1:0] {IDLE, SQ, CB, DONE} state_t;
    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  xr;
    logic [15:0] mc;
    logic [7:0]  mq;
    logic [23:0] acc;
    logic [23:0] addend;
    logic [23:0] acc_next;
    assign addend   = {8'b0, mc} << cnt;
    assign acc_next = mq[0] ? acc + addend : acc;
    assign busy_o   = start_i | (state != IDLE);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            xr    <= '0;
            mc    <= '0;
            mq    <= '0;
            acc   <= '0;
            y_bo  <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    xr    <= x_bi;
                    mc    <= {8'b0, x_bi};
                    mq    <= x_bi;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= SQ;
                end
                SQ: begin
                    acc <= acc_next;
                    mq  <= mq >> 1;
                    cnt <= cnt + 3'd1;
                    // final x^2 becomes the multiplicand of the second pass
                    if (cnt == 3'd7) begin
                        mc    <= acc_next[15:0];
                        mq    <= xr;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CB;
                    end
                end
                CB: begin
                    acc <= acc_next;
                    mq  <= mq >> 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= DONE;
                end
                DONE: begin
                    y_bo  <= acc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cube.sv
// tb_cube: directed tests for cube, checked every cycle against a latency/arithmetic model.
module tb_cube;
    logic        clk = 0;
    logic        rst_i = 0;
    logic        start_i = 0;
    logic [7:0]  x_bi = 0;
    logic        busy_o;
    logic [23:0] y_bo;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_left = 0;
    logic [23:0] m_y = 0;
    logic [23:0] m_pend = 0;
    int          acc_cnt = 0;
    int          last_acc = 0;
    int          sweep_base = 0;
    bit          sweep = 0;
    bit          live = 0;

    cube dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .x_bi(x_bi),
        .busy_o(busy_o),
        .y_bo(y_bo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // model: an accepted start yields x^3 on y exactly 17 edges later
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_left <= 0;
            m_y    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_left == 0) begin
                if (start_i) begin
                    m_left  <= 17;
                    m_pend  <= 24'(x_bi) * 24'(x_bi) * 24'(x_bi);
                    acc_cnt <= acc_cnt + 1;
                    last_acc <= cyc;
                    if (sweep && acc_cnt > sweep_base) chk("interval", cyc - last_acc, 18);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_y <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy", {31'b0, busy_o}, {31'b0, start_i | (m_left != 0)});
            chk("y", {8'b0, y_bo}, {8'b0, m_y});
        end
    end

    task automatic run(input logic [7:0] x, input logic [23:0] exp);
        @(posedge clk); #2;
        start_i = 1;
        x_bi = x;
        @(posedge clk); #2;
        start_i = 0;
        x_bi = 8'($urandom);
        repeat (16) @(posedge clk);
        #2 chk("busy_at_e16", {31'b0, busy_o}, 1);
        @(posedge clk);
        #2 chk("busy_after_e17", {31'b0, busy_o}, 0);
        chk("y_lit", {8'b0, y_bo}, {8'b0, exp});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        live = 1;
        chk("reset_y", {8'b0, y_bo}, 0);
        chk("reset_busy", {31'b0, busy_o}, 0);
        start_i = 1;
        #1 chk("reset_busy_start", {31'b0, busy_o}, 1);
        start_i = 0;
        rst_i = 1;
        run(8'd0, 24'd0);
        run(8'd1, 24'd1);
        run(8'd3, 24'd27);
        run(8'd5, 24'd125);
        run(8'd255, 24'hFD02FF);
        // second start at E5 and operand change must be ignored
        @(posedge clk); #2;
        start_i = 1;
        x_bi = 8'd4;
        @(posedge clk); #2;
        start_i = 0;
        x_bi = 8'd9;
        repeat (4) @(posedge clk);
        #2;
        start_i = 1;
        x_bi = 8'd9;
        @(posedge clk); #2;
        start_i = 0;
        x_bi = 8'd77;
        repeat (12) @(posedge clk);
        #2 chk("ignore_y", {8'b0, y_bo}, 64);
        // abort mid-operation with asynchronous reset
        @(posedge clk); #2;
        start_i = 1;
        x_bi = 8'd200;
        @(posedge clk); #2;
        start_i = 0;
        repeat (10) @(posedge clk);
        #2 rst_i = 0;
        #1 chk("abort_busy", {31'b0, busy_o}, 0);
        chk("abort_y", {8'b0, y_bo}, 0);
        @(posedge clk); #2;
        rst_i = 1;
        run(8'd2, 24'd8);
        // exhaustive sweep with start held high
        @(posedge clk); #2;
        sweep_base = acc_cnt;
        sweep = 1;
        start_i = 1;
        for (int i = 0; i < 256; i++) begin
            int t;
            x_bi = 8'(i);
            t = 0;
            while (acc_cnt == sweep_base + i && t < 40) begin
                @(posedge clk); #2;
                t++;
            end
            chk("accept", acc_cnt, sweep_base + i + 1);
        end
        start_i = 0;
        repeat (17) @(posedge clk);
        #2 chk("sweep_last_y", {8'b0, y_bo}, 32'hFD02FF);
        sweep = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cube.md
# cube

- Sequential unsigned cube unit: computes y = x³ for an 8-bit operand, giving an exact 24-bit result.
- It is the inverse companion to the design's integer cube-root block and uses the same start/busy handshake.
- Built from its own shift-add multiplier, which runs two back-to-back passes (x·x, then x²·x).
- Intended for self-checking cube-root/cube round-trips and for any datapath that needs a cube without a DSP multiplier.

## Interface
- Parameters: none. All widths are fixed (8-bit in, 24-bit out).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- x_bi  in  8  unsigned operand; sampled on the accepting edge.
- busy_o  out  1  combinational: start_i OR (state ≠ IDLE).
- y_bo  out  24  unsigned result register; holds the last completed cube.

## Operation
- Registers:
  - state (IDLE, SQ, CB, DONE)
  - 3-bit iteration counter cnt
  - 8-bit operand register xr
  - 16-bit multiplicand mc
  - 8-bit multiplier shift register mq
  - 24-bit accumulator acc
  - 24-bit result y
- IDLE:
  - If start_i=1 at the edge: xr←x_bi, mc←{8'b0,x_bi}, mq←x_bi, acc←0, cnt←0, next state SQ.
  - Otherwise hold all registers.
- SQ (x·x, 8 iterations):
  - Each edge: if mq[0], acc←acc+(mc<<cnt); then mq←mq>>1 and cnt←cnt+1.
  - On the edge where cnt=7: mc←acc_next[15:0] (the final x²), mq←xr, acc←0, cnt←0, next state CB.
- CB (x²·x, 8 iterations):
  - Same add/shift rule, with a 24-bit accumulator.
  - On the edge where cnt=7: acc holds x³, next state DONE.
- DONE: y←acc, next state IDLE.
- Arithmetic is unsigned and exact:
  - x² ≤ 65025 fits in 16 bits.
  - x³ ≤ 16581375 (0xFD02FF) fits in 24 bits, so no truncation or overflow is possible.
- start_i is ignored outside IDLE. No queuing, and an in-flight operation is never restarted.
- x_bi may change freely after the accepting edge; only xr is used.
- Illegal or unused state encodings go to IDLE on the next edge.

## Timing
- Reset (rst_i=0, asynchronous):
  - state=IDLE; cnt, xr, mc, mq, acc all 0; y_bo=0.
  - busy_o then equals start_i.
- Reset is honoured mid-operation: the computation is aborted and y_bo is cleared to 0. The next operation requires a fresh start after reset is released.
- Let edge E0 be the edge that accepts start. Then:
  - SQ occupies edges E1..E8.
  - CB occupies edges E9..E16.
  - DONE is the state after E16; at edge E17, y_bo is updated and state returns to IDLE.
- Latency: y_bo is valid with the new value after E17 (17 cycles after acceptance).
- busy_o:
  - High combinationally in the start cycle (before E0).
  - High from E0 through E17.
  - Low after E17 unless start_i is high again.
- Back-to-back operation: start_i held high at E17 is not accepted (state is DONE). It is accepted at E18, so the minimum issue interval is 18 cycles.
- y_bo is stable between updates. It changes only at the DONE→IDLE edge or on reset.

## Test plan
- Reset, then x_bi=0 with a 1-cycle start: busy_o high for the start cycle + 17 cycles; y_bo=0 after E17.
- Sequential inputs x=1, 3, 5: y_bo = 1, 27, 125 respectively, each exactly 17 cycles after its accepting edge.
- x=255: y_bo=16581375 (0xFD02FF), confirming the full-width product with no truncation.
- Start with x=4, then pulse start_i with x_bi=9 at E5: the second pulse is ignored, x_bi changes are ignored, and y_bo=64.
- Start with x=200, assert rst_i=0 at E10: busy_o and y_bo go to 0 immediately; after release, start with x=2 gives y_bo=8.
- Exhaustive sweep x=0..255 with start held continuously high: every result equals x³, and consecutive acceptances are 18 cycles apart.
